decode_stage: RTL and testbench

- Registered, parametrised RV32I decode stage between fetch and execute.
- Accepts one instruction word plus PC per handshake and emits a fully decoded control/operand bundle one cycle later.
- Handles backpressure through a 2-entry output buffer (main register plus skid register) and supports pipeline flush.
- Full sign-extended immediates for all formats, illegal-instruction flagging, optional M-extension decode.

---
 rtl/decode_pkg.sv | 76 +++++++
 rtl/decode_comb.sv | 116 +++++++++++
 rtl/decode_stage.sv | 113 +++++++++++
 tb/tb_decode_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, alu_op classes and the decoded bundle.
package decode_pkg;

    localparam int DEC_XLEN     = 32;
    localparam int DEC_REG_W    = 5;
    localparam int DEC_ALUCTL_W = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [DEC_ALUCTL_W-1:0] ALU_AND    = 4'b0000;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_OR     = 4'b0001;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_ADD    = 4'b0010;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_XOR    = 4'b0011;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_SLL    = 4'b0100;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_SRL    = 4'b0101;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_SUB    = 4'b0110;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_SLT    = 4'b0111;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_SLTU   = 4'b1000;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_SRA    = 4'b1001;
    localparam logic [DEC_ALUCTL_W-1:0] ALU_PASS_B = 4'b1010;

    localparam logic [1:0] ALUOP_ADDR   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_UPPER  = 2'b11;

    typedef struct packed {
        logic [DEC_XLEN-1:0]     pc;
        logic [DEC_XLEN-1:0]     imm;
        logic [DEC_REG_W-1:0]    rd;
        logic [DEC_REG_W-1:0]    rs1;
        logic [DEC_REG_W-1:0]    rs2;
        logic [2:0]              func3;
        logic [1:0]              alu_op;
        logic [DEC_ALUCTL_W-1:0] alu_control;
        logic                    alu_src;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    reg_write;
        logic                    branch;
        logic                    jump;
        logic                    illegal;
        logic                    md_valid;
        logic [2:0]              md_op;
    } dec_bundle_t;

    // alt selects SUB/SRA; it is ignored for every other func3.
    function automatic logic [DEC_ALUCTL_W-1:0] alu_ctl_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction-to-bundle decoder, zero latency, no flow control.
// M-extension decode is enabled by defining DECODE_MEXT_EN.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [DEC_XLEN-1:0] pc,
    output dec_bundle_t         bundle
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        bundle       = '0;
        bundle.pc    = pc;
        bundle.rd    = instr[11:7];
        bundle.rs1   = instr[19:15];
        bundle.rs2   = instr[24:20];
        bundle.func3 = f3;
        case (opc)
            OPC_LOAD: begin
                bundle.imm         = {{20{instr[31]}}, instr[31:20]};
                bundle.alu_src     = 1'b1;
                bundle.mem_read    = 1'b1;
                bundle.mem_to_reg  = 1'b1;
                bundle.reg_write   = 1'b1;
                bundle.alu_control = ALU_ADD;
                bundle.alu_op      = ALUOP_ADDR;
            end
            OPC_STORE: begin
                bundle.imm         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                bundle.alu_src     = 1'b1;
                bundle.mem_write   = 1'b1;
                bundle.alu_control = ALU_ADD;
                bundle.alu_op      = ALUOP_ADDR;
            end
            OPC_OPIMM: begin
                bundle.imm         = {{20{instr[31]}}, instr[31:20]};
                bundle.alu_src     = 1'b1;
                bundle.reg_write   = 1'b1;
                bundle.alu_op      = ALUOP_ARITH;
                bundle.alu_control = alu_ctl_arith(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                bundle.illegal     = ((f3 == 3'b001) && (f7 != F7_BASE)) ||
                                     ((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OPC_OP: begin
                bundle.alu_op = ALUOP_ARITH;
                if ((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
                    bundle.alu_control = alu_ctl_arith(f3, f7[5]);
                    bundle.reg_write   = 1'b1;
                end else if (f7 == F7_MULDIV) begin
`ifdef DECODE_MEXT_EN
                    bundle.alu_control = ALU_ADD;
                    bundle.md_valid    = 1'b1;
                    bundle.md_op       = f3;
                    bundle.reg_write   = 1'b1;
`else
                    bundle.illegal     = 1'b1;
`endif
                end else begin
                    bundle.illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                bundle.imm         = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                bundle.branch      = 1'b1;
                bundle.alu_op      = ALUOP_BRANCH;
                bundle.alu_control = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                bundle.illegal     = (f3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                bundle.imm         = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                bundle.alu_src     = 1'b1;
                bundle.jump        = 1'b1;
                bundle.reg_write   = 1'b1;
                bundle.alu_control = ALU_ADD;
                bundle.alu_op      = ALUOP_UPPER;
            end
            OPC_JALR: begin
                bundle.imm         = {{20{instr[31]}}, instr[31:20]};
                bundle.alu_src     = 1'b1;
                bundle.jump        = 1'b1;
                bundle.reg_write   = 1'b1;
                bundle.alu_control = ALU_ADD;
                bundle.alu_op      = ALUOP_UPPER;
                bundle.illegal     = (f3 != 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                bundle.imm         = {instr[31:12], 12'b0};
                bundle.alu_src     = 1'b1;
                bundle.reg_write   = 1'b1;
                bundle.alu_op      = ALUOP_UPPER;
                bundle.alu_control = (opc == OPC_LUI) ? ALU_PASS_B : ALU_ADD;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: bundle.illegal = 1'b1;
        endcase
        if (bundle.illegal) begin
            bundle.mem_read  = 1'b0;
            bundle.mem_write = 1'b0;
            bundle.reg_write = 1'b0;
            bundle.branch    = 1'b0;
            bundle.jump      = 1'b0;
        end
        if (bundle.rd == '0) begin
            bundle.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one cycle latency, main + skid output registers, flush support.
// in_ready is registered (skid empty); M-extension decode is enabled by defining DECODE_MEXT_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUCTL_W   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       imm,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [2:0]            func3,
    output logic [1:0]            alu_op,
    output logic [ALUCTL_W-1:0]   alu_control,
    output logic                  alu_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  branch,
    output logic                  jump,
    output logic                  illegal,
    output logic                  md_valid,
    output logic [2:0]            md_op
);

    dec_bundle_t dec_bundle;
    dec_bundle_t main_q, main_d, skid_q, skid_d;
    logic        main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic        accept;

    decode_comb u_decode_comb (
        .instr  (in_instr),
        .pc     (in_pc),
        .bundle (dec_bundle)
    );

    assign in_ready = !skid_vld_q;
    assign accept   = in_valid && in_ready;

    // The skid entry only fills while main is held, so main empty implies skid empty.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_ready) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = dec_bundle;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = dec_bundle;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_valid   = main_vld_q;
    assign out_pc      = main_q.pc;
    assign imm         = main_q.imm;
    assign rd          = main_q.rd;
    assign rs1         = main_q.rs1;
    assign rs2         = main_q.rs2;
    assign func3       = main_q.func3;
    assign alu_op      = main_q.alu_op;
    assign alu_control = main_q.alu_control;
    assign alu_src     = main_q.alu_src;
    assign mem_read    = main_q.mem_read;
    assign mem_write   = main_q.mem_write;
    assign mem_to_reg  = main_q.mem_to_reg;
    assign reg_write   = main_q.reg_write;
    assign branch      = main_q.branch;
    assign jump        = main_q.jump;
    assign illegal     = main_q.illegal;
    assign md_valid    = main_q.md_valid;
    assign md_op       = main_q.md_op;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors then random traffic against a 2-deep queue model.
module tb_decode_stage;

    logic        clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3, md_op;
    logic [1:0]  alu_op;
    logic [3:0]  alu_control;
    logic        alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, illegal, md_valid;

    decode_stage dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .imm(imm),
        .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .alu_op(alu_op),
        .alu_control(alu_control), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .branch(branch), .jump(jump), .illegal(illegal), .md_valid(md_valid), .md_op(md_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3, md_op;
        logic [1:0]  alu_op;
        logic [3:0]  ctl;
        logic        src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, illegal, md_valid;
        bit          imm_care, op_care, ctl_care, src_care;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    endtask

    // Reference decode written from the ISA field rules, ALU codes taken as plain numbers.
    function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [3:0]  arith_tab [8];
        bit          legal, wr, nop;
        arith_tab = '{4'd2, 4'd4, 4'd7, 4'd8, 4'd3, 4'd5, 4'd1, 4'd0};
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '{default: '0};
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
        legal = 1; wr = 0; nop = 0;
        case (opc)
            7'h03: begin e.imm = int'($signed(w[31:20])); e.mem_read = 1; e.mem_to_reg = 1; wr = 1;
                         e.alu_op = 0; e.ctl = 4'd2; e.ctl_care = 1; e.src = 1; e.src_care = 1; end
            7'h23: begin e.imm = int'($signed({w[31:25], w[11:7]})); e.mem_write = 1;
                         e.alu_op = 0; e.ctl = 4'd2; e.ctl_care = 1; e.src = 1; e.src_care = 1; end
            7'h13: begin e.imm = int'($signed(w[31:20])); wr = 1; e.alu_op = 2; e.src = 1; e.src_care = 1;
                         if (f3 == 1) legal = (f7 == 0);
                         if (f3 == 5) legal = (f7 == 0) || (f7 == 7'h20);
                         e.ctl = (f3 == 5 && f7 == 7'h20) ? 4'd9 : arith_tab[f3]; e.ctl_care = 1; end
            7'h33: begin e.imm = 0; wr = 1; e.alu_op = 2; e.src = 0; e.src_care = 1;
                         if (f7 == 0) begin e.ctl = arith_tab[f3]; e.ctl_care = 1; end
                         else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
                             e.ctl = (f3 == 0) ? 4'd6 : 4'd9; e.ctl_care = 1; end
`ifdef DECODE_MEXT_EN
                         else if (f7 == 7'h01) begin e.md_valid = 1; e.md_op = f3; end
`endif
                         else legal = 0; end
            7'h63: begin e.imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                         e.branch = 1; e.alu_op = 1; legal = !(f3 == 2 || f3 == 3); end
            7'h6F: begin e.imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                         e.jump = 1; wr = 1; e.alu_op = 3; end
            7'h67: begin e.imm = int'($signed(w[31:20])); e.jump = 1; wr = 1; e.alu_op = 3; legal = (f3 == 0); end
            7'h37: begin e.imm = w[31:12] * 4096; wr = 1; e.alu_op = 3; e.ctl = 4'd10; e.ctl_care = 1; end
            7'h17: begin e.imm = w[31:12] * 4096; wr = 1; e.alu_op = 3; e.ctl = 4'd2; e.ctl_care = 1; end
            7'h0F, 7'h73: nop = 1;
            default: legal = 0;
        endcase
        e.illegal = !legal;
        if (!legal) begin
            e.mem_read = 0; e.mem_write = 0; e.branch = 0; e.jump = 0; e.md_valid = 0; e.md_op = 0;
            e.ctl_care = 0; e.src_care = 0; wr = 0;
        end
        e.reg_write = wr && (e.rd != 0);
        e.imm_care  = legal && !nop;
        e.op_care   = legal && !nop;
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("out_pc", out_pc, e.pc);
            if (e.imm_care) chk("imm", imm, e.imm);
            chk("rd", rd, e.rd);
            chk("rs1", rs1, e.rs1);
            chk("rs2", rs2, e.rs2);
            chk("func3", func3, e.f3);
            if (e.op_care)  chk("alu_op", alu_op, e.alu_op);
            if (e.ctl_care) chk("alu_control", alu_control, e.ctl);
            if (e.src_care) chk("alu_src", alu_src, e.src);
            chk("mem_read", mem_read, e.mem_read);
            chk("mem_write", mem_write, e.mem_write);
            chk("mem_to_reg", mem_to_reg, e.mem_to_reg);
            chk("reg_write", reg_write, e.reg_write);
            chk("branch", branch, e.branch);
            chk("jump", jump, e.jump);
            chk("illegal", illegal, e.illegal);
            chk("md_valid", md_valid, e.md_valid);
            chk("md_op", md_op, e.md_op);
        end
    endtask

    // Called just after a falling edge: check, drive the next edge's inputs, advance the model.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bit drain, acc;
        compare_all();
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
        drain = (exp_q.size() > 0) && ordy;
        acc   = v && (exp_q.size() < 2);
        if (fl) exp_q.delete();
        else begin
            if (drain) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_dec(w, pc));
        end
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [12];
        logic [6:0]  f7s [4];
        logic [31:0] w;
        opcs = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
        f7s  = '{7'h00, 7'h20, 7'h01, 7'h00};
        opcs[11] = 7'($urandom);
        f7s[3]   = 7'($urandom);
        w = $urandom;
        w[6:0]   = opcs[$urandom_range(0, 11)];
        w[31:25] = f7s[$urandom_range(0, 3)];
        return w;
    endfunction

    initial begin
        reset_n = 1'b0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm", imm, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_ctl", {alu_control, alu_op, rd, reg_write, mem_read, mem_write, branch, jump}, 0);
        reset_n = 1'b1;

        step(1, 32'hFFF10093, 32'h100, 1, 0);
        chk("addi_vld", out_valid, 1); chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_rd", rd, 1); chk("addi_rs1", rs1, 2); chk("addi_src", alu_src, 1);
        chk("addi_wr", reg_write, 1); chk("addi_ctl", alu_control, 4'b0010);
        step(1, 32'h00512423, 32'h104, 1, 0);
        chk("sw_imm", imm, 8); chk("sw_rs2", rs2, 5); chk("sw_mw", mem_write, 1);
        chk("sw_wr", reg_write, 0); chk("sw_mr", mem_read, 0);
        step(1, 32'hFE000EE3, 32'h108, 1, 0);
        chk("beq_imm", imm, 32'hFFFFFFFC); chk("beq_br", branch, 1);
        chk("beq_aluop", alu_op, 2'b01); chk("beq_wr", reg_write, 0);
        step(1, 32'h00000000, 32'h10C, 1, 0);
        chk("zero_illegal", illegal, 1);
        chk("zero_flags", {mem_read, mem_write, reg_write, branch, jump}, 0);
        step(1, 32'h022081B3, 32'h110, 1, 0);
`ifdef DECODE_MEXT_EN
        chk("mul_md", md_valid, 1); chk("mul_mdop", md_op, 0); chk("mul_rd", rd, 3);
`else
        chk("mul_illegal", illegal, 1); chk("mul_md_off", md_valid, 0);
`endif
        step(0, 0, 0, 1, 0);

        // Three back-to-back with execute stalled, then released.
        step(1, 32'h00100093, 32'h200, 0, 0);
        step(1, 32'h00200113, 32'h204, 0, 0);
        chk("stall_in_ready", in_ready, 0);
        step(1, 32'h00300193, 32'h208, 0, 0);
        chk("stall_hold_pc", out_pc, 32'h200);
        step(1, 32'h00300193, 32'h208, 1, 0);
        chk("rel_pc2", out_pc, 32'h204); chk("rel_in_ready", in_ready, 1);
        step(1, 32'h00300193, 32'h208, 1, 0);
        chk("rel_pc3", out_pc, 32'h208);
        step(0, 0, 0, 1, 0);
        chk("rel_empty", out_valid, 0);

        // Flush with both entries full and a new instruction offered.
        step(1, 32'h00400213, 32'h300, 0, 0);
        step(1, 32'h00500293, 32'h304, 0, 0);
        step(1, 32'h00600313, 32'h308, 1, 1);
        chk("flush_vld", out_valid, 0); chk("flush_rdy", in_ready, 1);
        step(0, 0, 0, 1, 0);
        chk("flush_no_stale", out_valid, 0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
